// File: rtl/iir_biquad_df1.sv
// -----------------------------------------------------------------------------
// iir_biquad_df1
// Direct Form I biquad filter core with a single time-shared multiplier.
//   y[n] = b0*x[n] + b1*x1 + b2*x2 - a1*y1 - a2*y2
// Coefficients are signed Q2.30 values already normalised by a0. Each sample
// takes five MAC cycles, then the rounded/saturated result is held on the
// output stream until downstream accepts it.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cr_b0..cr_a2         coefficient inputs (COEF_WIDTH_P, Q_BITS_P fraction)
//   cr_coef_update       pulse: load cr_* into the active coefficient set
//   cr_clear_state       pulse: zero the delay line and clear sr_overflow
//   x_valid/x_ready/x_data  input sample stream
//   y_valid/y_ready/y_data  output sample stream
//   sr_overflow          sticky flag: an output saturated
// -----------------------------------------------------------------------------
module iir_biquad_df1 #(
  parameter int DATA_WIDTH_P = 24,
  parameter int COEF_WIDTH_P = 32,
  parameter int Q_BITS_P     = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COEF_WIDTH_P-1:0] cr_b0,
  input  logic [COEF_WIDTH_P-1:0] cr_b1,
  input  logic [COEF_WIDTH_P-1:0] cr_b2,
  input  logic [COEF_WIDTH_P-1:0] cr_a1,
  input  logic [COEF_WIDTH_P-1:0] cr_a2,
  input  logic                    cr_coef_update,
  input  logic                    cr_clear_state,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [DATA_WIDTH_P-1:0] x_data,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [DATA_WIDTH_P-1:0] y_data,
  output logic                    sr_overflow
);

  localparam int PROD_W = DATA_WIDTH_P + COEF_WIDTH_P;
  localparam int ACC_W  = PROD_W + 3;
  localparam int RES_W  = ACC_W - Q_BITS_P;
  localparam int HI_W   = RES_W - DATA_WIDTH_P + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_e;

  state_e                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [DATA_WIDTH_P-1:0]   x_q, x_d;
  logic [DATA_WIDTH_P-1:0]   x1_q, x1_d, x2_q, x2_d;
  logic [DATA_WIDTH_P-1:0]   y1_q, y1_d, y2_q, y2_d;
  logic [COEF_WIDTH_P-1:0]   b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [COEF_WIDTH_P-1:0]   a1_q, a1_d, a2_q, a2_d;
  logic                      coef_pend_q, coef_pend_d;
  logic                      clr_pend_q, clr_pend_d;
  logic                      y_valid_q, y_valid_d;
  logic [DATA_WIDTH_P-1:0]   y_data_q, y_data_d;
  logic                      ovf_q, ovf_d;

  logic                      in_idle;
  logic                      accept;
  logic                      load_coef;
  logic                      do_clear;
  logic [COEF_WIDTH_P-1:0]   coef_sel;
  logic [DATA_WIDTH_P-1:0]   samp_sel;
  logic [PROD_W-1:0]         prod;
  logic [ACC_W-1:0]          acc_ext;
  logic [ACC_W-1:0]          acc_sum;
  logic [RES_W-1:0]          res;
  logic [HI_W-1:0]           res_hi;
  logic                      sat;
  logic [DATA_WIDTH_P-1:0]   y_sat;

  assign in_idle = (state_q == ST_IDLE);
  assign x_ready = in_idle && !coef_pend_q && !clr_pend_q;
  assign accept  = x_valid && x_ready;

  // Updates and clears requested while a sample is in flight wait for IDLE,
  // so the in-flight sample always finishes with the state it started with.
  assign load_coef = in_idle && (cr_coef_update || coef_pend_q);
  assign do_clear  = in_idle && (cr_clear_state || clr_pend_q);

  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (defaults first); a path that leaves one unassigned infers a latch.
  always_comb begin
    coef_sel = b0_q;
    samp_sel = x_q;
    case (cnt_q)
      3'd0:    begin coef_sel = b0_q; samp_sel = x_q;  end
      3'd1:    begin coef_sel = b1_q; samp_sel = x1_q; end
      3'd2:    begin coef_sel = b2_q; samp_sel = x2_q; end
      3'd3:    begin coef_sel = a1_q; samp_sel = y1_q; end
      3'd4:    begin coef_sel = a2_q; samp_sel = y2_q; end
      default: begin coef_sel = b0_q; samp_sel = x_q;  end
    endcase

    // Both operands sign-extended to the product width; the low PROD_W bits
    // of the product are the exact signed result.
    prod    = {{DATA_WIDTH_P{coef_sel[COEF_WIDTH_P-1]}}, coef_sel} *
              {{COEF_WIDTH_P{samp_sel[DATA_WIDTH_P-1]}}, samp_sel};
    acc_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // Feedback (a) terms are subtracted.
    acc_sum = (cnt_q >= 3'd3) ? (acc_q - acc_ext) : (acc_q + acc_ext);

    // Adding 2^(Q-1) then shifting right by Q equals floor(acc / 2^Q) plus
    // bit Q-1 of acc: round half toward +inf without a wide adder.
    res    = acc_sum[ACC_W-1:Q_BITS_P] + RES_W'(acc_sum[Q_BITS_P-1]);
    res_hi = res[RES_W-1:DATA_WIDTH_P-1];
    // The result fits only if all bits above the output sign bit agree.
    sat    = !((&res_hi) || !(|res_hi));
    if (sat) begin
      y_sat = res[RES_W-1] ? {1'b1, {(DATA_WIDTH_P-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH_P-1){1'b1}}};
    end else begin
      y_sat = res[DATA_WIDTH_P-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    coef_pend_d = coef_pend_q;
    clr_pend_d  = clr_pend_q;
    y_valid_d   = y_valid_q;
    y_data_d    = y_data_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MAC;
          cnt_d   = 3'd0;
          acc_d   = '0;
          x_d     = x_data;
        end
      end
      ST_MAC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          state_d   = ST_OUT;
          y_valid_d = 1'b1;
          y_data_d  = y_sat;
          x2_d      = x1_q;
          x1_d      = x_q;
          y2_d      = y1_q;
          y1_d      = y_sat;
          if (sat) begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (y_ready) begin
          state_d   = ST_IDLE;
          y_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!in_idle && cr_coef_update) begin
      coef_pend_d = 1'b1;
    end
    if (!in_idle && cr_clear_state) begin
      clr_pend_d = 1'b1;
    end

    if (load_coef) begin
      b0_d        = cr_b0;
      b1_d        = cr_b1;
      b2_d        = cr_b2;
      a1_d        = cr_a1;
      a2_d        = cr_a2;
      coef_pend_d = 1'b0;
    end

    // Placed last so a clear overrides an overflow set in the same cycle.
    if (do_clear) begin
      x1_d       = '0;
      x2_d       = '0;
      y1_d       = '0;
      y2_d       = '0;
      ovf_d      = 1'b0;
      clr_pend_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      coef_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      y_valid_q   <= 1'b0;
      y_data_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      coef_pend_q <= coef_pend_d;
      clr_pend_q  <= clr_pend_d;
      y_valid_q   <= y_valid_d;
      y_data_q    <= y_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign y_valid     = y_valid_q;
  assign y_data      = y_data_q;
  assign sr_overflow = ovf_q;

endmodule

// File: doc/iir_biquad_df1.md
# iir_biquad_df1

Fixed-point Direct Form I biquad filter core that consumes normalised coefficient sets (b0/a0, b1/a0, b2/a0, a1/a0, a2/a0) produced by the team's biquad coefficient calculation and filters a stream of signed audio samples. It sits in the DSP chain between the sample source and downstream mixing/output stages. A single time-shared multiplier is used: five MAC cycles per sample, with valid/ready handshakes on both the input and the output stream.

## Interface
- DATA_WIDTH_P, 24, signed sample width of x and y
- COEF_WIDTH_P, 32, signed coefficient width
- Q_BITS_P, 30, fractional bits of coefficients (Q2.30: range [-2.0, 2.0))
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cr_b0, cr_b1, cr_b2, cr_a1, cr_a2  in  COEF_WIDTH_P each  coefficient inputs, already divided by a0
- cr_coef_update  in  1  pulse: load cr_* into the active coefficient set
- cr_clear_state  in  1  pulse: zero delay line x1,x2,y1,y2 and clear sr_overflow
- x_valid  in  1  input sample valid
- x_ready  out  1  core can accept a sample
- x_data  in  DATA_WIDTH_P  input sample
- y_valid  out  1  output sample valid
- y_ready  in  1  downstream accepts output
- y_data  out  DATA_WIDTH_P  filtered sample
- sr_overflow  out  1  sticky: an output saturated

## Operation
- y[n] = b0·x[n] + b1·x1 + b2·x2 − a1·y1 − a2·y2; x1/x2/y1/y2 are the previous inputs and the previous saturated outputs.
- FSM states: IDLE, MAC (5 cycles, counter 0..4 selecting b0·x, b1·x1, b2·x2, a1·y1, a2·y2; a-terms subtracted), OUT.
- IDLE -> MAC on x_valid && x_ready (x_data captured). MAC -> OUT after count 4, with round/saturate in the same transition. OUT -> IDLE on y_ready.
- Accumulator: signed, DATA_WIDTH_P+COEF_WIDTH_P+3 bits, cleared on acceptance; no internal wrap.
- Rounding: add 2^(Q_BITS_P−1), then arithmetic shift right by Q_BITS_P (round half toward +inf).
- Saturation to [−2^(DATA_WIDTH_P−1), 2^(DATA_WIDTH_P−1)−1]; on clip, set sr_overflow.
- On entering OUT: x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
- Coefficient update: a cr_coef_update seen in IDLE loads immediately. Seen in MAC/OUT, it sets a pending flag and the load happens on the first IDLE cycle. The sample in flight always uses the old set.
- cr_clear_state: same pending mechanism as the coefficient update. If it coincides with setting sr_overflow, clear wins.
- x_ready = (state == IDLE) && no pending update/clear.
- Reset values: state IDLE, all coefficients 0, delay line 0, y_valid 0, y_data 0, sr_overflow 0, pending flags 0. x_ready is 1 from the first cycle after reset release.
- Reset asserted mid-operation: immediately returns to the reset values; the in-flight sample is discarded.

## Timing
- Acceptance on edge E0; MAC products accumulate on edges E1..E5.
- y_data registered and y_valid=1 after edge E5; visible in cycle 6 after acceptance.
- y_valid and y_data are held stable until y_ready. The return to IDLE happens on the handshake edge; x_ready rises in the following cycle (unless pending).
- Maximum throughput is one sample per 7 cycles with y_ready held high.
- Pending load/clear takes 1 IDLE cycle with x_ready=0 before acceptance resumes.
- x_ready is never high while y_valid is high.

## Test plan
- Passthrough: b0=2^30, others 0; x=1000 then −5 -> y=1000, −5. y_valid appears 6 cycles after each acceptance; x_ready returns 1 cycle after each y handshake.
- Delay: b2=2^30, others 0; x=7,8,9 -> y=0,0,7.
- Feedback: b0=2^30, a1=−2^29 (y=x+0.5·y1); x=1024,0,0,0 -> y=1024,512,256,128.
- Rounding and saturation:
  - b0=2^29 (0.5); x=3 -> y=2; x=−3 -> y=−1.
  - b0=3·2^29 (1.5); x=8388607 -> y=8388607 and sr_overflow=1.
  - x=−8388608 -> y=−8388608.
  - cr_clear_state -> sr_overflow=0, delay line zero.
- Backpressure: y_ready low for 10 cycles during OUT -> y_valid=1, y_data constant, x_ready=0 throughout. Releasing y_ready completes exactly one output with no duplicate.
- Update and reset mid-operation:
  - cr_coef_update pulsed during MAC (new b0=2^29 vs old 2^30, x=100 twice) -> y=100 then 50, with x_ready low for one extra IDLE cycle.
  - rst_n pulled low during MAC -> y_valid=0, y_data=0, coefficients=0 asynchronously. The next sample produces y=0.
